// File: rtl/game_pkg.sv
// Shared game screen constants: mode encodings decoded by the compositor and
// the sequencer's logical state type.
package game_pkg;

    localparam int unsigned MODE_W     = 3;
    localparam int unsigned OVER_CNT_W = 5;

    localparam logic [MODE_W-1:0] MODE_START = 3'd0;
    localparam logic [MODE_W-1:0] MODE_PLAY  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_PAUSE = 3'd2;
    localparam logic [MODE_W-1:0] MODE_OVER  = 3'd3;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    function automatic logic [MODE_W-1:0] state_to_mode(input game_state_e s);
        case (s)
            ST_PLAY:  return MODE_PLAY;
            ST_PAUSE: return MODE_PAUSE;
            ST_OVER:  return MODE_OVER;
            default:  return MODE_START;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-flop synchronizer, stable-level debouncer and
// one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_q2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync_q2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/game_mode_ctrl.sv
// START/PLAY/PAUSE/OVER game sequencer with frame-aligned mode publication.
// Optional GAME_AUTO_RESTART_EN: OVER returns to START after OVER_HOLD_TICKS.
module game_mode_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MIN_OVER_TICKS  = 4,
    parameter int unsigned OVER_HOLD_TICKS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_4hz,
    input  logic              frame_start,
    input  logic              btn_start,
    input  logic              btn_pause,
    input  logic              game_over_evt,
    output logic [MODE_W-1:0] mode,
    output logic              mode_chg,
    output logic              play_en,
    output logic              blink
);

`ifdef GAME_AUTO_RESTART_EN
    localparam logic AUTO_RESTART = 1'b1;
`else
    localparam logic AUTO_RESTART = 1'b0;
`endif

    logic                  start_press;
    logic                  pause_press;
    game_state_e           state;
    game_state_e           state_nxt;
    logic [OVER_CNT_W-1:0] over_cnt;
    logic [OVER_CNT_W-1:0] over_cnt_nxt;
    logic                  blink_nxt;
    logic                  over_exit;
    logic [MODE_W-1:0]     state_mode;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start),
        .press (start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_pause),
        .press (pause_press)
    );

    // Early start presses in OVER are dropped, not remembered.
    assign over_exit = (start_press && (over_cnt >= OVER_CNT_W'(MIN_OVER_TICKS)))
                     || (AUTO_RESTART && (over_cnt == OVER_CNT_W'(OVER_HOLD_TICKS)));

    assign state_mode = state_to_mode(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_START;
            over_cnt <= '0;
            blink    <= 1'b1;
            play_en  <= 1'b0;
        end else begin
            state    <= state_nxt;
            over_cnt <= over_cnt_nxt;
            blink    <= blink_nxt;
            play_en  <= (state_nxt == ST_PLAY);
        end
    end

    always_comb begin
        state_nxt    = state;
        over_cnt_nxt = over_cnt;
        blink_nxt    = blink;

        case (state)
            ST_START: if (start_press) state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (game_over_evt)    state_nxt = ST_OVER;
                else if (pause_press) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: if (start_press || pause_press) state_nxt = ST_PLAY;
            ST_OVER:  if (over_exit) state_nxt = ST_START;
            default:  state_nxt = ST_START;
        endcase

        // A transition overrides any coincident tick.
        if (state_nxt != state) begin
            blink_nxt = 1'b1;
            if (state_nxt == ST_OVER) over_cnt_nxt = '0;
        end else if ((state == ST_START) || (state == ST_PAUSE)) begin
            if (tick_4hz) blink_nxt = ~blink;
        end else begin
            blink_nxt = 1'b1;
            if ((state == ST_OVER) && tick_4hz && (over_cnt != {OVER_CNT_W{1'b1}}))
                over_cnt_nxt = over_cnt + OVER_CNT_W'(1);
        end
    end

    // Mode only moves on frame boundaries so overlays never tear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= MODE_START;
            mode_chg <= 1'b0;
        end else begin
            mode_chg <= 1'b0;
            if (frame_start) begin
                mode     <= state_mode;
                mode_chg <= (mode != state_mode);
            end
        end
    end

endmodule

// File: doc/game_mode_ctrl.md
# game_mode_ctrl

Top-level game state sequencer for the VGA game screen path. It debounces the start and pause buttons, and runs the START/PLAY/PAUSE/OVER state machine. It publishes the 3-bit `mode` consumed by the screen compositor, and updates it only at frame boundaries so that overlays never tear mid-frame. It also drives the blink enable for start/pause text and the gameplay enable for the game logic.

## Interface
- `DEBOUNCE_CYCLES`, 250000: stable-level cycles required before a button change is accepted (10 ms at 25 MHz).
- `MIN_OVER_TICKS`, 4: minimum `tick_4hz` pulses spent in OVER before `btn_start` is honoured.
- `OVER_HOLD_TICKS`, 12: `tick_4hz` pulses after which OVER auto-returns to START (only with `GAME_AUTO_RESTART_EN`).
- `clk` input 1: pixel/system clock.
- `rst` input 1: asynchronous, active-high reset.
- `tick_4hz` input 1: one-cycle enable pulse at 4 Hz, synchronous to `clk`.
- `frame_start` input 1: one-cycle pulse at the start of each VGA frame (vertical blank).
- `btn_start` input 1: raw start button, asynchronous, active high.
- `btn_pause` input 1: raw pause button, asynchronous, active high.
- `game_over_evt` input 1: one-cycle pulse from game logic on player loss.
- `mode` output 3: displayed screen mode. 0 = START, 1 = PLAY, 2 = PAUSE, 3 = OVER. Values 4–7 are never driven.
- `mode_chg` output 1: one-cycle pulse in the first cycle `mode` holds a new value.
- `play_en` output 1: high while the logical state is PLAY.
- `blink` output 1: text blink phase for START/PAUSE overlays.

## Operation
- Inputs `btn_*` pass through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A press is a one-cycle pulse on the debounced level's rising edge. Releases generate nothing.
- The logical state `state` updates on the same cycle an event is seen:
  - START: `start_press` -> PLAY.
  - PLAY: `game_over_evt` -> OVER. Otherwise `pause_press` -> PAUSE. `game_over_evt` wins if both arrive in the same cycle.
  - PAUSE: `pause_press` or `start_press` -> PLAY. `game_over_evt` is ignored.
  - OVER: `start_press` with `over_cnt >= MIN_OVER_TICKS` -> START. An earlier press is discarded, not queued.
  - Events not listed for a state are ignored.
- `over_cnt` (5 bits):
  - Cleared on entry to OVER.
  - Increments on `tick_4hz` while in OVER.
  - Saturates at 31.
- `blink`:
  - Set to 1 on any state transition.
  - Toggles on `tick_4hz` while in START or PAUSE.
  - Held at 1 in PLAY/OVER.
- `mode` is loaded with `state` on the clock edge where `frame_start` = 1.
  - If several transitions occur within one frame, only the state at the boundary is shown.
  - `mode_chg` = 1 for exactly one cycle after a load that changed the value.
- `play_en` follows `state` directly, not `mode`.

## Timing
- Reset values:
  - `state` = START, `mode` = 0.
  - `mode_chg` = 0, `play_en` = 0, `blink` = 1.
  - `over_cnt` = 0, debounced levels = 0, debounce counters = 0.
- Reset mid-debounce or mid-OVER discards all progress. After deassertion, a held button reads as a new press once `DEBOUNCE_CYCLES` is met.
- Button latency, raw edge to press pulse: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- State latency: `state` and `play_en` change the cycle after the press/event pulse.
- `mode` latency: up to one frame after the state change. If `frame_start` and the event coincide, `mode` picks up the old state; the new state appears at the next frame.
- `tick_4hz` coincident with a transition: the transition wins. `over_cnt` and `blink` take their entry values.

## Configuration
- `GAME_AUTO_RESTART_EN` defined:
  - OVER also -> START when `over_cnt == OVER_HOLD_TICKS`, checked on the cycle the count reaches it.
  - `btn_start` remains usable after `MIN_OVER_TICKS`.
- Undefined: OVER exits only via `btn_start`. `OVER_HOLD_TICKS` is unused.

## Structure
- Shared package `game_pkg`:
  - Mode encodings `MODE_START`/`MODE_PLAY`/`MODE_PAUSE`/`MODE_OVER`.
  - `MODE_W` = 3.
  - The same constants the compositor decodes.
- Sub-module `btn_debounce`, instantiated twice:
  - Contains the synchronizer, counter, level register, and rising-edge press pulse.
  - Parameter: `DEBOUNCE_CYCLES`.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 4, `MIN_OVER_TICKS` = 4, `OVER_HOLD_TICKS` = 12, and `frame_start` every 100 cycles.
- Reset release, then `btn_start` high for 10 cycles -> press pulse 7 cycles after the rising edge; `play_en` = 1 next cycle; `mode` = 1 with `mode_chg` pulse at the next `frame_start`.
- `btn_start` glitch of 3 cycles -> no press; `state` and `mode` stay 0.
- In PLAY, `game_over_evt` and `pause_press` in the same cycle -> `state` OVER, `mode` = 3 at the next frame; never 2.
- In OVER, press after 2 ticks -> ignored. Press after 4 ticks -> START, `mode` = 0.
- With `GAME_AUTO_RESTART_EN`, no press -> START on the 12th tick. Without it, `mode` stays 3 after 20 ticks.
- PLAY -> PAUSE -> PLAY within one frame -> `mode` stays 1 and no `mode_chg`; `blink` toggles on each `tick_4hz` only while in PAUSE.
